// File: rtl/vid_capture.sv
// Single-frame video capture: packs pairs of 12-bit pixels into 32-bit words
// and streams them with addresses through a 2-entry FIFO.
module vid_capture #(
  parameter int H_PIX   = 320,
  parameter int V_LINES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] vid_pixel,
  input  logic        vid_pixsync,
  input  logic        vid_hblank,
  input  logic        vid_vblank,
  input  logic        vid_locked,
  input  logic        cap_arm,
  output logic        cap_busy,
  output logic        cap_done,
  output logic        cap_err,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [15:0] wr_addr,
  output logic [31:0] wr_data
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        last_vblank_q;
  logic        in_line_q, in_line_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [11:0] even_q, even_d;

  logic [47:0] fifo_q [2];
  logic        wptr_q, rptr_q;
  logic [1:0]  fcnt_q;

  logic        start_beat, cap_beat, visible, line_end;
  logic        push, push_ok, pop, overflow;
  logic        lock_err, len_err, short_err, err_any;
  logic [15:0] lines_next;
  logic        frame_done;
  logic [47:0] push_word, head;

  // Beat classification: the WAIT_FRAME beat that starts a frame is itself capture data.
  always_comb begin
    start_beat = (state_q == WAIT_FRAME) && vid_pixsync && vid_locked &&
                 !vid_vblank && last_vblank_q;
    cap_beat   = vid_pixsync && vid_locked && ((state_q == CAPTURE) || start_beat);
    visible    = cap_beat && !vid_hblank && !vid_vblank;
    line_end   = cap_beat && vid_hblank && in_line_q;
    lines_next = line_cnt_q + {15'd0, line_end};
    frame_done = line_end && (lines_next == 16'(V_LINES));

    push      = visible && pix_cnt_q[0];
    pop       = (fcnt_q != 2'd0) && wr_ready;
    push_ok   = push && ((fcnt_q != 2'd2) || pop);
    overflow  = push && (fcnt_q == 2'd2) && !pop;
    push_word = {addr_q, 4'd0, vid_pixel, 4'd0, even_q};

    lock_err  = vid_pixsync && !vid_locked &&
                ((state_q == WAIT_FRAME) || (state_q == CAPTURE));
    len_err   = line_end && (pix_cnt_q != 16'(H_PIX));
    short_err = cap_beat && vid_vblank && (lines_next < 16'(V_LINES));
    err_any   = lock_err || len_err || short_err || overflow;
  end

  always_comb begin
    state_d    = state_q;
    in_line_d  = in_line_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    addr_d     = addr_q;
    err_d      = err_q;
    even_d     = even_q;
    cap_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cap_arm) begin
          state_d    = WAIT_FRAME;
          err_d      = 1'b0;
          in_line_d  = 1'b0;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          addr_d     = '0;
        end
      end
      WAIT_FRAME: if (start_beat) state_d = CAPTURE;
      CAPTURE:    if (frame_done) state_d = DRAIN;
      DRAIN: begin
        if (fcnt_q == 2'd0) begin
          cap_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (visible) begin
      in_line_d = 1'b1;
      pix_cnt_d = (pix_cnt_q == 16'hFFFF) ? pix_cnt_q : pix_cnt_q + 16'd1;
      if (!pix_cnt_q[0]) even_d = vid_pixel;
    end
    if (line_end) begin
      in_line_d  = 1'b0;
      pix_cnt_d  = '0;
      line_cnt_d = lines_next;
    end
    if (push_ok) addr_d = addr_q + 16'd1;

    if (err_any) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_vblank_q <= 1'b0;
      in_line_q     <= 1'b0;
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      addr_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_line_q  <= in_line_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      if (vid_pixsync) last_vblank_q <= vid_vblank;
    end
  end

  always_ff @(posedge clk) begin
    even_q <= even_d;
  end

  // Output FIFO: an error flushes it in the same edge that moves the FSM to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      fcnt_q <= 2'd0;
    end else if (err_any) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      fcnt_q <= 2'd0;
    end else begin
      if (push_ok) wptr_q <= ~wptr_q;
      if (pop)     rptr_q <= ~rptr_q;
      fcnt_q <= fcnt_q + {1'b0, push_ok} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wptr_q] <= push_word;
  end

  always_comb begin
    head     = fifo_q[rptr_q];
    wr_valid = (fcnt_q != 2'd0);
    wr_addr  = wr_valid ? head[47:32] : 16'd0;
    wr_data  = wr_valid ? head[31:0]  : 32'd0;
    cap_busy = (state_q != IDLE);
    cap_err  = err_q;
  end

endmodule

// File: tb/tb_vid_capture.sv
// Bench for vid_capture on a reduced 8x6 frame: scenario table, random frames
// against a pixel-array reference, and hand-timed corner sequences.
module tb_vid_capture;
  localparam int H = 8;
  localparam int V = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] vid_pixel;
  logic        vid_pixsync, vid_hblank, vid_vblank, vid_locked, cap_arm;
  logic        cap_busy, cap_done, cap_err, wr_valid, wr_ready;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  vid_capture #(.H_PIX(H), .V_LINES(V)) dut (
    .clk(clk), .rst(rst), .vid_pixel(vid_pixel), .vid_pixsync(vid_pixsync),
    .vid_hblank(vid_hblank), .vid_vblank(vid_vblank), .vid_locked(vid_locked),
    .cap_arm(cap_arm), .cap_busy(cap_busy), .cap_done(cap_done), .cap_err(cap_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  int total = 0;
  int passed = 0;
  logic [15:0] got_addr[$];
  logic [31:0] got_data[$];
  int done_cnt = 0;
  int stab_err = 0;
  logic hold_q = 1'b0;
  logic [15:0] hold_a;
  logic [31:0] hold_d;
  logic [11:0] frame_pix [V][H+2];

  int g_nlines, g_bad_line, g_bad_len, g_unlock_line, g_gap_mode, g_rdy_mode;
  bit g_arm_noise;

  typedef struct {
    string name;
    int nlines; int bad_line; int bad_len; int unlock_line;
    int gap_mode; int rdy_mode;
    bit exp_err; int exp_done; int exp_words;
  } vec_t;
  vec_t tbl[8];

  // Write-stream observer, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_valid && wr_ready) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
    if (cap_done) done_cnt++;
    if (hold_q && wr_valid && (wr_addr != hold_a || wr_data != hold_d)) stab_err++;
    hold_q = wr_valid && !wr_ready;
    hold_a = wr_addr;
    hold_d = wr_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end, got time %0t required < 1000000", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    case (g_rdy_mode)
      0: wr_ready = 1'b0;
      1: wr_ready = 1'b1;
      2: wr_ready = ~wr_ready;
      default: wr_ready = vid_pixsync ? 1'b1 : 1'($urandom_range(0, 1));
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [11:0] p, input logic hb, input logic vb, input logic lk);
    int n;
    vid_pixel = p; vid_hblank = hb; vid_vblank = vb; vid_locked = lk; vid_pixsync = 1'b1;
    cyc();
    vid_pixsync = 1'b0;
    cap_arm = 1'b0;
    n = (g_gap_mode == 0) ? 0 : (g_gap_mode == 1) ? 3 : int'($urandom_range(0, 3));
    repeat (n) cyc();
  endtask

  task automatic clear_log();
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
    stab_err = 0;
  endtask

  task automatic fill_formula();
    for (int l = 0; l < V; l++)
      for (int x = 0; x < H + 2; x++) frame_pix[l][x] = 12'(l * 37 + x);
  endtask

  task automatic fill_random();
    for (int l = 0; l < V; l++)
      for (int x = 0; x < H + 2; x++) frame_pix[l][x] = 12'($urandom);
  endtask

  task automatic set_plain();
    g_nlines = V; g_bad_line = -1; g_bad_len = H; g_unlock_line = -1;
    g_gap_mode = 0; g_rdy_mode = 1; g_arm_noise = 1'b0;
  endtask

  // Reference: word i is the i-th pixel pair of the frame in raster order.
  function automatic logic [31:0] exp_word(input int i);
    int l, x;
    l = i / (H / 2);
    x = 2 * (i % (H / 2));
    if (l >= V) return 32'hDEADBEEF;
    return {4'h0, frame_pix[l][x+1], 4'h0, frame_pix[l][x]};
  endfunction

  task automatic run_frame(input bit arm);
    int len;
    if (arm) begin
      cap_arm = 1'b1;
      cyc();
      cap_arm = 1'b0;
    end
    beat(12'd0, 1'b1, 1'b1, 1'b1);
    beat(12'd0, 1'b1, 1'b1, 1'b1);
    for (int l = 0; l < g_nlines; l++) begin
      len = (l == g_bad_line) ? g_bad_len : H;
      for (int x = 0; x < len; x++) begin
        if (g_arm_noise) cap_arm = 1'($urandom_range(0, 1));
        beat(frame_pix[l][x], 1'b0, 1'b0, !(l == g_unlock_line && x == 0));
      end
      beat(12'd0, 1'b1, 1'b0, 1'b1);
      beat(12'd0, 1'b1, 1'b0, 1'b1);
    end
    repeat (3) beat(12'd0, 1'b1, 1'b1, 1'b1);
    repeat (40) cyc();
  endtask

  task automatic check_frame(input string nm, input bit e_err, input int e_done, input int e_words);
    int bad;
    chk({nm, ".err"}, cap_err, e_err);
    chk({nm, ".done"}, done_cnt, e_done);
    chk({nm, ".words"}, got_data.size(), e_words);
    bad = 0;
    for (int i = 0; i < got_data.size(); i++)
      if (got_addr[i] != 16'(i) || got_data[i] != exp_word(i)) bad++;
    chk({nm, ".content_bad"}, bad, 0);
    chk({nm, ".busy"}, cap_busy, 0);
    chk({nm, ".valid"}, wr_valid, 0);
    chk({nm, ".stable"}, stab_err, 0);
  endtask

  initial begin
    int n, bl;
    tbl[0] = '{"full",            V, -1,    H,   -1, 0, 1, 1'b0, 1, V*H/2};
    tbl[1] = '{"bp_toggle",       V, -1,    H,   -1, 1, 2, 1'b0, 1, V*H/2};
    tbl[2] = '{"short_line",      V,  3,    H-1, -1, 0, 1, 1'b1, 0, 3*H/2 + (H-1)/2};
    tbl[3] = '{"long_line",       V,  2,    H+1, -1, 0, 1, 1'b1, 0, 2*H/2 + H/2};
    tbl[4] = '{"short_frame",     3, -1,    H,   -1, 0, 1, 1'b1, 0, 3*H/2};
    tbl[5] = '{"unlock_cap",      V, -1,    H,    1, 0, 1, 1'b1, 0, H/2};
    tbl[6] = '{"overflow",        V, -1,    H,   -1, 0, 0, 1'b1, 0, 0};
    tbl[7] = '{"last_line_short", V,  V-1,  H-1, -1, 0, 1, 1'b1, 0, (V-1)*H/2 + (H-1)/2};

    set_plain();
    rst = 1'b0; vid_pixel = '0; vid_pixsync = 1'b0; vid_hblank = 1'b0; vid_vblank = 1'b0;
    vid_locked = 1'b1; cap_arm = 1'b0; wr_ready = 1'b0;
    repeat (3) cyc();
    chk("rst.busy", cap_busy, 0);
    chk("rst.done", cap_done, 0);
    chk("rst.err", cap_err, 0);
    chk("rst.valid", wr_valid, 0);
    chk("rst.addr", wr_addr, 0);
    chk("rst.data", wr_data, 0);
    rst = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) begin
      set_plain();
      g_nlines = tbl[i].nlines; g_bad_line = tbl[i].bad_line; g_bad_len = tbl[i].bad_len;
      g_unlock_line = tbl[i].unlock_line; g_gap_mode = tbl[i].gap_mode; g_rdy_mode = tbl[i].rdy_mode;
      fill_formula();
      clear_log();
      run_frame(1'b1);
      check_frame(tbl[i].name, tbl[i].exp_err, tbl[i].exp_done, tbl[i].exp_words);
      if (i == 0 && got_data.size() > 0) chk("full.first_word", got_data[0], 32'h0001_0000);
    end

    for (int r = 0; r < 3; r++) begin
      set_plain();
      g_gap_mode = 2; g_rdy_mode = 3; g_arm_noise = 1'b1;
      fill_random();
      clear_log();
      run_frame(1'b1);
      check_frame($sformatf("rand%0d", r), 1'b0, 1, V*H/2);
    end

    for (int r = 0; r < 2; r++) begin
      set_plain();
      bl = int'($urandom_range(0, V - 1));
      g_bad_line = bl; g_bad_len = H - 1;
      fill_random();
      clear_log();
      run_frame(1'b1);
      check_frame($sformatf("rand_short%0d", r), 1'b1, 0, bl*H/2 + (H-1)/2);
    end

    // Overflow timing with the sink stalled: two words fit, the third errors.
    set_plain();
    g_rdy_mode = 0;
    fill_formula();
    clear_log();
    cap_arm = 1'b1; cyc(); cap_arm = 1'b0;
    chk("ovf.busy_armed", cap_busy, 1);
    beat(12'd0, 1'b1, 1'b1, 1'b1);
    beat(frame_pix[0][0], 1'b0, 1'b0, 1'b1);
    chk("ovf.valid_before_pair", wr_valid, 0);
    beat(frame_pix[0][1], 1'b0, 1'b0, 1'b1);
    chk("ovf.valid_first", wr_valid, 1);
    chk("ovf.addr_first", wr_addr, 0);
    chk("ovf.data_first", wr_data, 32'h0001_0000);
    beat(frame_pix[0][2], 1'b0, 1'b0, 1'b1);
    beat(frame_pix[0][3], 1'b0, 1'b0, 1'b1);
    chk("ovf.err_two_words", cap_err, 0);
    chk("ovf.head_held", wr_data, 32'h0001_0000);
    beat(frame_pix[0][4], 1'b0, 1'b0, 1'b1);
    beat(frame_pix[0][5], 1'b0, 1'b0, 1'b1);
    chk("ovf.err", cap_err, 1);
    chk("ovf.valid_flushed", wr_valid, 0);
    chk("ovf.idle", cap_busy, 0);
    chk("ovf.done", done_cnt, 0);

    // Armed mid-frame: nothing is written until a vblank-to-visible transition.
    set_plain();
    fill_formula();
    clear_log();
    repeat (3) beat(12'd5, 1'b0, 1'b0, 1'b1);
    cap_arm = 1'b1; cyc(); cap_arm = 1'b0;
    for (int l = 0; l < 2; l++) begin
      for (int x = 0; x < H; x++) beat(12'(x), 1'b0, 1'b0, 1'b1);
      beat(12'd0, 1'b1, 1'b0, 1'b1);
      beat(12'd0, 1'b1, 1'b0, 1'b1);
    end
    repeat (4) cyc();
    chk("midarm.no_words", got_data.size(), 0);
    chk("midarm.busy", cap_busy, 1);
    run_frame(1'b0);
    check_frame("midarm", 1'b0, 1, V*H/2);

    // Lock lost while waiting for the frame start.
    set_plain();
    clear_log();
    cap_arm = 1'b1; cyc(); cap_arm = 1'b0;
    chk("unlock_wait.err_before", cap_err, 0);
    beat(12'd0, 1'b1, 1'b1, 1'b0);
    chk("unlock_wait.err", cap_err, 1);
    chk("unlock_wait.busy", cap_busy, 0);

    // Asynchronous reset in the middle of a capture.
    set_plain();
    fill_formula();
    clear_log();
    cap_arm = 1'b1; cyc(); cap_arm = 1'b0;
    beat(12'd0, 1'b1, 1'b1, 1'b1);
    beat(12'd0, 1'b1, 1'b1, 1'b1);
    for (int x = 0; x < H; x++) beat(frame_pix[0][x], 1'b0, 1'b0, 1'b1);
    beat(12'd0, 1'b1, 1'b0, 1'b1);
    for (int x = 0; x < 5; x++) beat(frame_pix[1][x], 1'b0, 1'b0, 1'b1);
    g_rdy_mode = 0;
    beat(frame_pix[1][5], 1'b0, 1'b0, 1'b1);
    chk("rstmid.valid_before", wr_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid.busy", cap_busy, 0);
    chk("rstmid.valid", wr_valid, 0);
    chk("rstmid.addr", wr_addr, 0);
    chk("rstmid.data", wr_data, 0);
    chk("rstmid.err", cap_err, 0);
    chk("rstmid.done", cap_done, 0);
    n = got_data.size();
    g_rdy_mode = 1;
    repeat (3) cyc();
    rst = 1'b1;
    for (int x = 6; x < H; x++) beat(frame_pix[1][x], 1'b0, 1'b0, 1'b1);
    beat(12'd0, 1'b1, 1'b0, 1'b1);
    repeat (5) cyc();
    chk("rstmid.no_more_writes", got_data.size(), n);
    chk("rstmid.no_done", done_cnt, 0);
    chk("rstmid.idle", cap_busy, 0);
    clear_log();
    run_frame(1'b1);
    check_frame("after_rst", 1'b0, 1, V*H/2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
